mem_wb_stage: RTL
=================

Name: mem_wb_stage

Overview:
- Pipeline stage directly downstream of the execute ALU. Consumes its result, write-enable, rd, funct3, data-memory enables and effective address.
- Performs load/store accesses over a req/ack data-memory bus, with byte-lane alignment, store byte enables and load sign/zero extension.
- Produces the register-file writeback triple. Stalls upstream while a memory access is outstanding.

Parameters:
- TIMEOUT, 16, max BUSY cycles waiting for mem_ack before abort (>=2).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- alu_out  in  32  ALU result; store data for stores.
- alu_reg_w_en  in  1  non-memory op writes rd.
- alu_rd  in  5  destination register.
- f3  in  3  funct3 of the instruction in execute.
- d_r_en  in  1  load request.
- d_w_en  in  1  store request.
- d_add  in  32  effective byte address.
- mem_req  out  1  bus request, held until ack or abort.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word address {d_add[31:2],2'b00}.
- mem_wdata  out  32  lane-replicated store data.
- mem_be  out  4  byte enables.
- mem_rdata  in  32  read data, valid when mem_ack=1.
- mem_ack  in  1  access complete.
- stall  out  1  upstream must hold its outputs.
- wb_en  out  1  register write strobe.
- wb_rd  out  5  register index.
- wb_data  out  32  register write data.
- misalign  out  1  one-cycle fault pulse.
- bus_err  out  1  one-cycle timeout pulse.

Behaviour:
- Reset (async, immediate): state IDLE, timeout counter 0. mem_req, mem_we, stall, wb_en, misalign, bus_err = 0. mem_addr, mem_wdata, wb_data = 0. mem_be = 0, wb_rd = 0.
- Reset mid-access drops mem_req at once; a later mem_ack is ignored.
- FSM states: IDLE, BUSY. stall = (state==BUSY), combinational from state only.
- IDLE, each edge, samples inputs. Classification:
  - d_w_en=1 → store (wins if d_r_en also 1).
  - else d_r_en=1 → load.
  - else → ALU op.
- ALU op: next cycle wb_en = alu_reg_w_en & (alu_rd!=0), wb_rd = alu_rd, wb_data = alu_out. Latency 1, no stall.
- Alignment check:
  - Halfword (f3[1:0]=01) needs d_add[0]=0.
  - Word (f3[1:0]=10, or any other f3 on a store) needs d_add[1:0]=0.
  - Byte is always aligned.
  - Misaligned load/store: no bus request, misalign=1 for one cycle, wb_en=0, stay IDLE.
- Aligned store, f3 coding:
  - 000 SB: mem_be = 1<<d_add[1:0], mem_wdata = {4{alu_out[7:0]}}.
  - 001 SH: mem_be = d_add[1] ? 1100 : 0011, mem_wdata = {2{alu_out[15:0]}}.
  - 010 and all others: SW, mem_be = 1111, mem_wdata = alu_out.
- Aligned load: mem_be = 1111, mem_we = 0. Latch f3, d_add[1:0] and alu_rd.
- Any aligned access: mem_req=1 and state→BUSY at the accepting edge. mem_addr/mem_we/mem_be/mem_wdata stay stable while mem_req=1.
- BUSY, mem_ack=1 at an edge: mem_req→0, state→IDLE, counter cleared. Inputs are not sampled on this edge; the held instruction is sampled on the next IDLE edge.
- Load writeback on completion: for one cycle wb_en = (rd!=0), wb_rd = latched rd, wb_data = extracted value:
  - LB/LBU (000/100): byte at lane d_add[1:0].
  - LH/LHU (001/101): halfword at d_add[1].
  - LW: full word. f3 011/110/111 are treated as LW.
  - 000/001 sign-extend; 100/101 zero-extend.
- Store completion: wb_en=0.
- BUSY, no ack: counter increments each cycle. At counter==TIMEOUT-1 without ack: abort (mem_req→0, IDLE), bus_err=1 for one cycle, wb_en=0. mem_ack on that same edge wins over the timeout.
- mem_ack while IDLE is ignored.
- wb_en, misalign and bus_err are single-cycle pulses; wb_rd/wb_data hold their last value otherwise.
- Minimum memory op cost: 2 cycles (accept edge + ack edge), then 1 IDLE sampling edge.

Test Plan:
- ALU op alu_out=0x0000_1234, rd=5, alu_reg_w_en=1 → next cycle wb_en=1, wb_rd=5, wb_data=0x1234, stall=0. Same op with rd=0 → wb_en=0.
- LB at d_add=0x103, memory word 0x80FF_0000, ack after 2 BUSY cycles → mem_addr=0x100, stall=1 for 2 cycles, wb_data=0xFFFF_FF80. LBU at the same address → wb_data=0x0000_0080.
- SH at d_add=0x202, alu_out=0xDEAD_BEEF → mem_be=1100, mem_wdata=0xBEEF_BEEF, mem_we=1, no wb_en. SB at 0x201 → mem_be=0010.
- LW at d_add=0x102 → misalign pulse, mem_req stays 0, no stall. LH at 0x101 → same.
- TIMEOUT=4, LW with no ack → mem_req high 4 cycles, then bus_err pulse, stall drops, wb_en=0. Repeat with ack on the 4th cycle → normal completion, no bus_err.
- Assert rst while BUSY → mem_req and stall drop immediately. A mem_ack after reset release produces no wb_en.

Source files
------------

// File: rtl/mem_wb_stage.sv
// Memory/writeback stage: issues aligned loads/stores on a req/ack bus, extends
// load data, and produces the register-file write strobe. Stalls upstream while busy.
module mem_wb_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_out,
  input  logic        alu_reg_w_en,
  input  logic [4:0]  alu_rd,
  input  logic [2:0]  f3,
  input  logic        d_r_en,
  input  logic        d_w_en,
  input  logic [31:0] d_add,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misalign,
  output logic        bus_err
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    ld_f3;
  logic [1:0]    ld_lane;
  logic [4:0]    ld_rd;

  assign stall = (state == BUSY);

  // Stores decode f3 exactly (only 000/001 are narrow); loads use f3[1:0].
  logic is_st, is_ld, acc_byte, acc_half, aligned;
  assign is_st    = d_w_en;
  assign is_ld    = ~d_w_en & d_r_en;
  assign acc_byte = is_st ? (f3 == 3'b000) : (f3[1:0] == 2'b00);
  assign acc_half = is_st ? (f3 == 3'b001) : (f3[1:0] == 2'b01);
  assign aligned  = acc_byte | (acc_half & ~d_add[0]) |
                    (~acc_byte & ~acc_half & (d_add[1:0] == 2'b00));

  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = alu_out;
    case (f3)
      3'b000: begin
        st_be    = 4'b0001 << d_add[1:0];
        st_wdata = {4{alu_out[7:0]}};
      end
      3'b001: begin
        st_be    = d_add[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{alu_out[15:0]}};
      end
      default: ;
    endcase
  end

  logic [31:0] rd_shift, ld_val;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  assign rd_shift = mem_rdata >> {ld_lane, 3'b000};
  assign ld_byte  = rd_shift[7:0];
  assign ld_half  = ld_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  always_comb begin
    ld_val = mem_rdata;
    case (ld_f3)
      3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_val = {24'd0, ld_byte};
      3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_val = {16'd0, ld_half};
      default: ld_val = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      wb_en     <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      misalign  <= 1'b0;
      bus_err   <= 1'b0;
      ld_f3     <= '0;
      ld_lane   <= '0;
      ld_rd     <= '0;
    end else begin
      wb_en    <= 1'b0;
      misalign <= 1'b0;
      bus_err  <= 1'b0;
      if (state == IDLE) begin
        if (is_st | is_ld) begin
          if (!aligned) begin
            misalign <= 1'b1;
          end else begin
            state     <= BUSY;
            cnt       <= '0;
            mem_req   <= 1'b1;
            mem_we    <= is_st;
            mem_addr  <= {d_add[31:2], 2'b00};
            mem_be    <= is_st ? st_be : 4'b1111;
            mem_wdata <= is_st ? st_wdata : mem_wdata;
            ld_f3     <= f3;
            ld_lane   <= d_add[1:0];
            ld_rd     <= alu_rd;
          end
        end else begin
          wb_en   <= alu_reg_w_en & (alu_rd != 5'd0);
          wb_rd   <= alu_rd;
          wb_data <= alu_out;
        end
      end else if (mem_ack) begin
        state   <= IDLE;
        cnt     <= '0;
        mem_req <= 1'b0;
        if (!mem_we) begin
          wb_en   <= (ld_rd != 5'd0);
          wb_rd   <= ld_rd;
          wb_data <= ld_val;
        end
      end else if (cnt == CNT_LAST) begin
        state   <= IDLE;
        cnt     <= '0;
        mem_req <= 1'b0;
        bus_err <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule
